// File: rtl/alu_mul_sequencer_if.sv
// Interface bundling the multiply request/response and the time-shared ALU port.
//   start/sgn/a/b : multiply request, sampled only while the sequencer is idle
//   busy/done     : status; done is a one-cycle pulse with result valid
//   result/zero   : product (low WIDTH bits) and registered zero flag
//   alu_a/b/op    : operands and opcode driven to the shared ALU
//   alu_c         : combinational ALU result returned to the sequencer
// Modports: master = requester + ALU side, slave = sequencer.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_c;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, sgn, a, b, alu_c,
    input  alu_a, alu_b, alu_op, busy, done, result, zero
  );

  modport slave (
    input  start, sgn, a, b, alu_c,
    output alu_a, alu_b, alu_op, busy, done, result, zero
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared 32-bit ALU.
// Signed operands are made positive with ALU subtracts (0 - x) before the
// add loop, and the product is negated afterwards when the signs differ.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_mul_sequencer_if.slave (request, status, result, ALU A/B/Op/C)
// Optional build macro: ALU_MUL_EARLY_TERM_EN -- leave the add loop as soon as
// the remaining multiplier bits are all zero (data-dependent latency).
module alu_mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  alu_mul_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StMul,
    StFix,
    StDone
  } stateT;

  stateT            stateQ, stateD;
  logic [WIDTH-1:0] mcandQ, mcandD;
  logic [WIDTH-1:0] mplierQ, mplierD;
  logic [WIDTH-1:0] accQ, accD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             negResQ, negResD;
  logic             sgnQ, sgnD;
  logic [WIDTH-1:0] resultQ;
  logic             zeroQ;
  logic             lastIter;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcandQ  <= '0;
      mplierQ <= '0;
      accQ    <= '0;
      cntQ    <= '0;
      negResQ <= 1'b0;
      sgnQ    <= 1'b0;
      resultQ <= '0;
      zeroQ   <= 1'b1;
    end else begin
      mcandQ  <= mcandD;
      mplierQ <= mplierD;
      accQ    <= accD;
      cntQ    <= cntD;
      negResQ <= negResD;
      sgnQ    <= sgnD;
      // Capture on entry to DONE so result is already valid while done is high.
      if (stateD == StDone) begin
        resultQ <= accD;
        zeroQ   <= (accD == '0);
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    stateD   = stateQ;
    mcandD   = mcandQ;
    mplierD  = mplierQ;
    accD     = accQ;
    cntD     = cntQ;
    negResD  = negResQ;
    sgnD     = sgnQ;
    lastIter = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.start) begin
          mcandD  = bus.a;
          mplierD = bus.b;
          accD    = '0;
          cntD    = '0;
          sgnD    = bus.sgn;
          negResD = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          if (bus.sgn && bus.a[WIDTH-1]) begin
            stateD = StNegA;
          end else if (bus.sgn && bus.b[WIDTH-1]) begin
            stateD = StNegB;
          end else begin
            stateD = StMul;
          end
        end
      end
      StNegA: begin
        mcandD = bus.alu_c;
        // mplier is untouched here, so its sign bit is still the captured b's.
        stateD = (sgnQ && mplierQ[WIDTH-1]) ? StNegB : StMul;
      end
      StNegB: begin
        mplierD = bus.alu_c;
        stateD  = StMul;
      end
      StMul: begin
        if (mplierQ[0]) begin
          accD = bus.alu_c;
        end
        mcandD   = mcandQ << 1;
        mplierD  = mplierQ >> 1;
        cntD     = cntQ + CNT_W'(1);
        lastIter = (cntQ == CNT_W'(WIDTH - 1));
`ifdef ALU_MUL_EARLY_TERM_EN
        if (mplierD == '0) begin
          lastIter = 1'b1;
        end
`endif
        if (lastIter) begin
          stateD = negResQ ? StFix : StDone;
        end
      end
      StFix: begin
        accD   = bus.alu_c;
        stateD = StDone;
      end
      StDone: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Outputs: ALU drive and status decoded from the current state
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = OpAdd;
    unique case (stateQ)
      StNegA: begin
        bus.alu_b  = mcandQ;
        bus.alu_op = OpSub;
      end
      StNegB: begin
        bus.alu_b  = mplierQ;
        bus.alu_op = OpSub;
      end
      StMul: begin
        bus.alu_a  = accQ;
        bus.alu_b  = mcandQ;
        bus.alu_op = OpAdd;
      end
      StFix: begin
        bus.alu_b  = accQ;
        bus.alu_op = OpSub;
      end
      default: begin
        bus.alu_op = OpAdd;
      end
    endcase
    bus.busy = (stateQ != StIdle) && (stateQ != StDone);
    bus.done = (stateQ == StDone);
  end

  assign bus.result = resultQ;
  assign bus.zero   = zeroQ;

endmodule
